alu_op_sequencer: RTL and testbench

- Multi-cycle control sequencer that drives the NRISC ALU operand path: the 4:1 operand-mux selects, the CMP2 force-to-minus-one control, the INCDEC force-to-one control and the ALU function code.
- Accepts one ALU operation per valid/ready handshake and steps it through one or two micro-ops.
- Captures the ALU result in an internal temp register (TMP), which also feeds back as mux input 3.
- Issues a single register-file write-back pulse per operation.

---
 rtl/nrisc_alu_pkg.sv | 40 ++++
 rtl/alu_uop_decode.sv | 62 ++++++
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_alu_pkg.sv
// Shared encodings for the NRISC ALU operand-path sequencer: opcodes, ALU function
// codes, operand-mux sources, FSM states and the packed micro-op control word.
package nrisc_alu_pkg;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_INC = 3'd5;
    localparam logic [2:0] OP_DEC = 3'd6;
    localparam logic [2:0] OP_NEG = 3'd7;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_XOR = 3'd4;

    localparam logic [1:0] SRC_REGA = 2'd0;
    localparam logic [1:0] SRC_REGB = 2'd1;
    localparam logic [1:0] SRC_IMM  = 2'd2;
    localparam logic [1:0] SRC_TMP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC1,
        ST_EXEC2,
        ST_WB
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       cmp2;
        logic       incdec;
        logic [2:0] func;
    } ctrl_t;

endpackage

// File: rtl/alu_uop_decode.sv
// Combinational micro-op decoder: {opcode, step, src_a, src_b} -> ALU control word.
// Step 1 exists only for NEG and adds one to the inverted operand held in TMP.
module alu_uop_decode
    import nrisc_alu_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic       step,
    input  logic [1:0] src_a,
    input  logic [1:0] src_b,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (step) begin
            ctrl.sel_a  = SRC_TMP;
            ctrl.incdec = 1'b1;
            ctrl.func   = FN_ADD;
        end else begin
            unique case (opcode)
                // NEG starts as NOT: all-ones XOR B gives ~B
                OP_NOT, OP_NEG: begin
                    ctrl.cmp2  = 1'b1;
                    ctrl.sel_b = src_b;
                    ctrl.func  = FN_XOR;
                end
                OP_ADD: begin
                    ctrl.sel_a = src_a;
                    ctrl.sel_b = src_b;
                    ctrl.func  = FN_ADD;
                end
                OP_SUB: begin
                    ctrl.sel_a = src_a;
                    ctrl.sel_b = src_b;
                    ctrl.func  = FN_SUB;
                end
                OP_AND: begin
                    ctrl.sel_a = src_a;
                    ctrl.sel_b = src_b;
                    ctrl.func  = FN_AND;
                end
                OP_OR: begin
                    ctrl.sel_a = src_a;
                    ctrl.sel_b = src_b;
                    ctrl.func  = FN_OR;
                end
                OP_INC: begin
                    ctrl.sel_a  = src_a;
                    ctrl.incdec = 1'b1;
                    ctrl.func   = FN_ADD;
                end
                OP_DEC: begin
                    ctrl.sel_a  = src_a;
                    ctrl.incdec = 1'b1;
                    ctrl.func   = FN_SUB;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// NRISC ALU operand-path sequencer: one op per handshake, 1-2 micro-ops, TMP capture, one write-back.
// Optional ALU_FLAGS_EN adds a FLAGS[2:0] = {C,N,Z} output captured on the final exec edge.
module alu_op_sequencer
    import nrisc_alu_pkg::*;
#(
    parameter int TAM   = 16,
    parameter int RADDR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [2:0]       OP_CODE,
    input  logic [1:0]       OP_SRC_A,
    input  logic [1:0]       OP_SRC_B,
    input  logic [RADDR-1:0] OP_RD,
    input  logic [TAM-1:0]   ALU_RESULT,
    input  logic             ALU_CARRY,
    output logic [3:0]       MUX_SEL_A,
    output logic [3:0]       MUX_SEL_B,
    output logic             CMP2,
    output logic             INCDEC,
    output logic [2:0]       ALU_FUNC,
    output logic [TAM-1:0]   TMP_Q,
    output logic             WB_EN,
    output logic [RADDR-1:0] WB_ADDR,
    output logic [TAM-1:0]   WB_DATA,
`ifdef ALU_FLAGS_EN
    output logic [2:0]       FLAGS,
`endif
    output logic             DONE
);

    state_t           state;
    logic [2:0]       op_q;
    logic [RADDR-1:0] rd_q;
    ctrl_t            ctrl_q;
    ctrl_t            dec_ctrl;
    logic [TAM-1:0]   tmp_q;
    logic [2:0]       dec_op;
    logic             dec_step;
    logic             final_exec;

    // Control words are registered one state early so they are stable during the state.
    assign dec_op   = (state == ST_IDLE) ? OP_CODE : op_q;
    assign dec_step = (state == ST_EXEC1);

    alu_uop_decode u_decode (
        .opcode (dec_op),
        .step   (dec_step),
        .src_a  (OP_SRC_A),
        .src_b  (OP_SRC_B),
        .ctrl   (dec_ctrl)
    );

    assign final_exec = ((state == ST_EXEC1) && (op_q != OP_NEG)) || (state == ST_EXEC2);

    assign MUX_SEL_A = {2'b00, ctrl_q.sel_a};
    assign MUX_SEL_B = {2'b00, ctrl_q.sel_b};
    assign CMP2      = ctrl_q.cmp2;
    assign INCDEC    = ctrl_q.incdec;
    assign ALU_FUNC  = ctrl_q.func;
    assign TMP_Q     = tmp_q;
    assign WB_DATA   = tmp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            tmp_q    <= '0;
            OP_READY <= 1'b0;
            WB_EN    <= 1'b0;
            WB_ADDR  <= '0;
            DONE     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (OP_VALID && OP_READY) begin
                        op_q     <= OP_CODE;
                        rd_q     <= OP_RD;
                        ctrl_q   <= dec_ctrl;
                        OP_READY <= 1'b0;
                        state    <= ST_EXEC1;
                    end else begin
                        OP_READY <= 1'b1;
                    end
                end
                ST_EXEC1: begin
                    tmp_q <= ALU_RESULT;
                    if (op_q == OP_NEG) begin
                        ctrl_q <= dec_ctrl;
                        state  <= ST_EXEC2;
                    end else begin
                        ctrl_q  <= '0;
                        WB_EN   <= 1'b1;
                        WB_ADDR <= rd_q;
                        DONE    <= 1'b1;
                        state   <= ST_WB;
                    end
                end
                ST_EXEC2: begin
                    tmp_q   <= ALU_RESULT;
                    ctrl_q  <= '0;
                    WB_EN   <= 1'b1;
                    WB_ADDR <= rd_q;
                    DONE    <= 1'b1;
                    state   <= ST_WB;
                end
                ST_WB: begin
                    WB_EN    <= 1'b0;
                    WB_ADDR  <= '0;
                    DONE     <= 1'b0;
                    OP_READY <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FLAGS <= '0;
        end else if (final_exec) begin
            FLAGS <= {ALU_CARRY, ALU_RESULT[TAM-1], (ALU_RESULT == '0)};
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ALU_CARRY ^ final_exec;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU/register environment plus an
// arithmetic reference model; FLAGS checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_op_sequencer;
    localparam int TAM   = 16;
    localparam int RADDR = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             OP_VALID = 1'b0;
    logic             OP_READY;
    logic [2:0]       OP_CODE = '0;
    logic [1:0]       OP_SRC_A = '0;
    logic [1:0]       OP_SRC_B = '0;
    logic [RADDR-1:0] OP_RD = '0;
    logic [TAM-1:0]   ALU_RESULT;
    logic             ALU_CARRY;
    logic [3:0]       MUX_SEL_A, MUX_SEL_B;
    logic             CMP2, INCDEC;
    logic [2:0]       ALU_FUNC;
    logic [TAM-1:0]   TMP_Q;
    logic             WB_EN;
    logic [RADDR-1:0] WB_ADDR;
    logic [TAM-1:0]   WB_DATA;
    logic             DONE;
`ifdef ALU_FLAGS_EN
    logic [2:0]       FLAGS;
`endif

    alu_op_sequencer #(.TAM(TAM), .RADDR(RADDR)) dut (
        .clk(clk), .rst(rst), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_CODE(OP_CODE), .OP_SRC_A(OP_SRC_A), .OP_SRC_B(OP_SRC_B), .OP_RD(OP_RD),
        .ALU_RESULT(ALU_RESULT), .ALU_CARRY(ALU_CARRY),
        .MUX_SEL_A(MUX_SEL_A), .MUX_SEL_B(MUX_SEL_B), .CMP2(CMP2), .INCDEC(INCDEC),
        .ALU_FUNC(ALU_FUNC), .TMP_Q(TMP_Q), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR),
        .WB_DATA(WB_DATA),
`ifdef ALU_FLAGS_EN
        .FLAGS(FLAGS),
`endif
        .DONE(DONE)
    );

    always #5 clk = ~clk;

    // Environment: register file read ports, immediate, operand muxes and the ALU itself.
    logic [15:0] reg_a = '0, reg_b = '0, imm = '0;
    logic [15:0] mux_a, mux_b, alu_a, alu_b;
    logic [16:0] alu_full;

    assign mux_a = (MUX_SEL_A[1:0] == 2'd0) ? reg_a : (MUX_SEL_A[1:0] == 2'd1) ? reg_b :
                   (MUX_SEL_A[1:0] == 2'd2) ? imm : TMP_Q;
    assign mux_b = (MUX_SEL_B[1:0] == 2'd0) ? reg_a : (MUX_SEL_B[1:0] == 2'd1) ? reg_b :
                   (MUX_SEL_B[1:0] == 2'd2) ? imm : TMP_Q;
    assign alu_a = CMP2 ? 16'hFFFF : mux_a;
    assign alu_b = INCDEC ? 16'h0001 : mux_b;

    always_comb begin
        alu_full = '0;
        case (ALU_FUNC)
            3'd0: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_full = {1'b0, alu_a & alu_b};
            3'd3: alu_full = {1'b0, alu_a | alu_b};
            3'd4: alu_full = {1'b0, alu_a ^ alu_b};
            default: alu_full = '0;
        endcase
    end
    assign ALU_RESULT = alu_full[15:0];
    assign ALU_CARRY  = alu_full[16];

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] model_tmp = '0;

    function automatic logic [15:0] opnd(input logic [1:0] s);
        case (s)
            2'd0: return reg_a;
            2'd1: return reg_b;
            2'd2: return imm;
            default: return model_tmp;
        endcase
    endfunction

    // Reference result {carry, value} straight from the operation definitions.
    function automatic logic [16:0] ref_op(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua, ub, r;
        logic c;
        ua = a; ub = b; c = 1'b0; r = 0;
        case (code)
            3'd0: r = 32'hFFFF - ub;
            3'd1: begin r = ua + ub; c = (r > 32'hFFFF); end
            3'd2: begin r = ua - ub; c = (ua < ub); end
            3'd3: r = ua & ub;
            3'd4: r = ua | ub;
            3'd5: begin r = ua + 1; c = (ua == 32'hFFFF); end
            3'd6: begin r = ua - 1; c = (ua == 0); end
            default: begin r = 32'h10000 - ub; c = (ub == 0); end
        endcase
        return {c, r[15:0]};
    endfunction

    function automatic logic [2:0] ref_func(input logic [2:0] code);
        case (code)
            3'd1, 3'd5: return 3'd0;
            3'd2, 3'd6: return 3'd1;
            3'd3:       return 3'd2;
            3'd4:       return 3'd3;
            default:    return 3'd4;
        endcase
    endfunction

    // Drives one handshake from a negedge and records what the DUT shows in cycles t+1..t+6.
    task automatic issue_op(input logic [2:0] code, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [2:0] rd, output int wb_cyc, output logic [15:0] wb_data,
                            output logic [2:0] wb_addr, output int wb_cnt, output int done_cnt,
                            output int rdy_cyc, output logic [12:0] ctl1, output logic [12:0] ctl2,
                            output logic [15:0] tmp2, output bit timeout);
        int w;
        wb_cyc = -1; wb_data = '0; wb_addr = '0; wb_cnt = 0; done_cnt = 0; rdy_cyc = -1;
        ctl1 = '0; ctl2 = '0; tmp2 = '0; timeout = 1'b0; w = 0;
        while (!OP_READY && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!OP_READY) begin
            timeout = 1'b1;
            return;
        end
        OP_VALID = 1'b1; OP_CODE = code; OP_SRC_A = sa; OP_SRC_B = sb; OP_RD = rd;
        @(posedge clk);
        #1 OP_VALID = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) ctl1 = {CMP2, INCDEC, ALU_FUNC, MUX_SEL_A, MUX_SEL_B};
            if (c == 2) begin
                ctl2 = {CMP2, INCDEC, ALU_FUNC, MUX_SEL_A, MUX_SEL_B};
                tmp2 = TMP_Q;
            end
            if (WB_EN) begin
                wb_cnt++;
                if (wb_cyc < 0) begin
                    wb_cyc = c; wb_data = WB_DATA; wb_addr = WB_ADDR;
                end
            end
            if (DONE) done_cnt++;
            if (OP_READY && rdy_cyc < 0) rdy_cyc = c;
        end
    endtask

    int wc, wn, dn, rc;
    logic [15:0] wd, t2;
    logic [2:0] wa;
    logic [12:0] c1, c2;
    bit to;

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({OP_READY, MUX_SEL_A, MUX_SEL_B, CMP2, INCDEC, ALU_FUNC, TMP_Q, WB_EN, WB_ADDR, WB_DATA, DONE} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%0b func=%0d tmp=%h wb_en=%0b done=%0b required all zero",
                     OP_READY, ALU_FUNC, TMP_Q, WB_EN, DONE);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (OP_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: got %0b required 1", OP_READY);
        end
    endtask

    task automatic test_add();
        reg_a = 16'h0003; reg_b = 16'h0004;
        issue_op(3'd1, 2'd0, 2'd1, 3'd5, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
        n_cmp++;
        if (to || wc !== 2 || wd !== 16'h0007 || wa !== 3'd5) begin
            n_err++;
            $display("FAIL add_wb: timeout=%0b cyc=%0d data=%h addr=%0d required cyc=2 data=0007 addr=5", to, wc, wd, wa);
        end
        n_cmp++;
        if (wn !== 1 || dn !== 1 || rc !== 3) begin
            n_err++;
            $display("FAIL add_pulses: wb=%0d done=%0d ready_cyc=%0d required 1 1 3", wn, dn, rc);
        end
        n_cmp++;
        if (c1 !== 13'b0_0_000_0000_0001) begin
            n_err++;
            $display("FAIL add_exec1_ctl: got %b required 0000000000001", c1);
        end
        model_tmp = 16'h0007;
    endtask

    task automatic test_neg();
        reg_b = 16'h0001;
        issue_op(3'd7, 2'd0, 2'd1, 3'd2, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
        n_cmp++;
        if (to || c1[12] !== 1'b1 || c1[10:8] !== 3'd4 || t2 !== 16'hFFFE) begin
            n_err++;
            $display("FAIL neg_exec1: timeout=%0b cmp2=%0b func=%0d tmp=%h required 1 4 fffe", to, c1[12], c1[10:8], t2);
        end
        n_cmp++;
        if (c2[7:4] !== 4'd3 || c2[11] !== 1'b1 || c2[10:8] !== 3'd0 || c2[12] !== 1'b0) begin
            n_err++;
            $display("FAIL neg_exec2: sel_a=%0d incdec=%0b func=%0d cmp2=%0b required 3 1 0 0", c2[7:4], c2[11], c2[10:8], c2[12]);
        end
        n_cmp++;
        if (wc !== 3 || wd !== 16'hFFFF || wa !== 3'd2 || wn !== 1 || dn !== 1 || rc !== 4) begin
            n_err++;
            $display("FAIL neg_wb: cyc=%0d data=%h addr=%0d wb=%0d done=%0d rdy=%0d required 3 ffff 2 1 1 4", wc, wd, wa, wn, dn, rc);
        end
        model_tmp = 16'hFFFF;
    endtask

    task automatic test_wrap();
        reg_a = 16'h0000;
        issue_op(3'd6, 2'd0, 2'd1, 3'd1, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
        n_cmp++;
        if (to || wc !== 2 || wd !== 16'hFFFF) begin
            n_err++;
            $display("FAIL dec_wrap: cyc=%0d data=%h required 2 ffff", wc, wd);
        end
        reg_a = 16'hFFFF;
        issue_op(3'd5, 2'd0, 2'd1, 3'd3, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
        n_cmp++;
        if (to || wc !== 2 || wd !== 16'h0000) begin
            n_err++;
            $display("FAIL inc_wrap: cyc=%0d data=%h required 2 0000", wc, wd);
        end
`ifdef ALU_FLAGS_EN
        n_cmp++;
        if (FLAGS !== 3'b101) begin
            n_err++;
            $display("FAIL inc_flags: got %b required 101", FLAGS);
        end
`endif
        model_tmp = 16'h0000;
    endtask

    task automatic test_not();
        reg_b = 16'h00FF;
        issue_op(3'd0, 2'd2, 2'd1, 3'd4, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
        n_cmp++;
        if (to || wc !== 2 || wd !== 16'hFF00 || wa !== 3'd4) begin
            n_err++;
            $display("FAIL not_wb: cyc=%0d data=%h addr=%0d required 2 ff00 4", wc, wd, wa);
        end
        n_cmp++;
        if (c1[10:8] !== 3'd4 || c1[11] !== 1'b0 || c1[12] !== 1'b1) begin
            n_err++;
            $display("FAIL not_exec1: func=%0d incdec=%0b cmp2=%0b required 4 0 1", c1[10:8], c1[11], c1[12]);
        end
        model_tmp = 16'hFF00;
    endtask

    task automatic test_random();
        logic [2:0] code, rd;
        logic [1:0] sa, sb;
        logic [16:0] exp;
        int exp_cyc;
        for (int i = 0; i < 40; i++) begin
            code = 3'($urandom_range(0, 7)); sa = 2'($urandom_range(0, 3));
            sb = 2'($urandom_range(0, 3)); rd = 3'($urandom_range(0, 7));
            reg_a = 16'($urandom); reg_b = 16'($urandom); imm = 16'($urandom);
            if (i % 8 == 0) reg_a = 16'hFFFF;
            exp = ref_op(code, opnd(sa), opnd(sb));
            exp_cyc = (code == 3'd7) ? 3 : 2;
            issue_op(code, sa, sb, rd, wc, wd, wa, wn, dn, rc, c1, c2, t2, to);
            n_cmp++;
            if (to || wc !== exp_cyc || wd !== exp[15:0] || wa !== rd || wn !== 1 || dn !== 1 || rc !== exp_cyc + 1) begin
                n_err++;
                $display("FAIL rand_op%0d code=%0d: cyc=%0d data=%h addr=%0d wb=%0d done=%0d rdy=%0d required %0d %h %0d 1 1 %0d",
                         i, code, wc, wd, wa, wn, dn, rc, exp_cyc, exp[15:0], rd, exp_cyc + 1);
            end
            n_cmp++;
            if (c1[10:8] !== ref_func(code) || c1[7:6] !== 2'b00 || c1[3:2] !== 2'b00) begin
                n_err++;
                $display("FAIL rand_ctl%0d code=%0d: func=%0d sel_a=%0d sel_b=%0d required func %0d upper bits 0",
                         i, code, c1[10:8], c1[7:4], c1[3:0], ref_func(code));
            end
`ifdef ALU_FLAGS_EN
            n_cmp++;
            if (FLAGS !== {exp[16], exp[15], exp[15:0] == 16'h0}) begin
                n_err++;
                $display("FAIL rand_flags%0d: got %b required %b", i, FLAGS, {exp[16], exp[15], exp[15:0] == 16'h0});
            end
`endif
            model_tmp = exp[15:0];
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int wbs;
        int w;
        wbs = 0; w = 0;
        reg_a = 16'h0010; reg_b = 16'h0020;
        while (!OP_READY && w < 10) begin @(negedge clk); w++; end
        OP_VALID = 1'b1; OP_CODE = 3'd1; OP_SRC_A = 2'd0; OP_SRC_B = 2'd1; OP_RD = 3'd6;
        for (int i = 0; i < 10; i++) begin
            if (OP_READY) acc.push_back(i);
            if (WB_EN) wbs++;
            @(negedge clk);
        end
        OP_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (WB_EN) wbs++;
            @(negedge clk);
        end
        n_cmp++;
        if (acc.size() != 4 || acc[0] != 0 || acc[1] != 3 || acc[2] != 6 || acc[3] != 9) begin
            n_err++;
            $display("FAIL b2b_accepts: count=%0d list=%p required 4 at 0,3,6,9", acc.size(), acc);
        end
        n_cmp++;
        if (wbs != 4) begin
            n_err++;
            $display("FAIL b2b_writebacks: got %0d required 4", wbs);
        end
        model_tmp = 16'h0030;
    endtask

    task automatic test_reset_mid_neg();
        int w;
        int bad;
        logic [3:0] rdy;
        w = 0; bad = 0; rdy = '0;
        reg_b = 16'h1234;
        while (!OP_READY && w < 10) begin @(negedge clk); w++; end
        OP_VALID = 1'b1; OP_CODE = 3'd7; OP_SRC_A = 2'd0; OP_SRC_B = 2'd1; OP_RD = 3'd7;
        @(posedge clk); #1 OP_VALID = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (INCDEC !== 1'b1 || MUX_SEL_A !== 4'd3) begin
            n_err++;
            $display("FAIL midneg_in_exec2: incdec=%0b sel_a=%0d required 1 3", INCDEC, MUX_SEL_A);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({OP_READY, MUX_SEL_A, MUX_SEL_B, CMP2, INCDEC, ALU_FUNC, TMP_Q, WB_EN, WB_ADDR, WB_DATA, DONE} !== '0) begin
            n_err++;
            $display("FAIL midneg_async_clear: ready=%0b incdec=%0b tmp=%h wb_en=%0b done=%0b required all zero",
                     OP_READY, INCDEC, TMP_Q, WB_EN, DONE);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy[k] = OP_READY;
            if (WB_EN || DONE) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midneg_no_wb: saw %0d wb/done cycles required 0", bad);
        end
        n_cmp++;
        if (rdy[1:0] !== 2'b10) begin
            n_err++;
            $display("FAIL midneg_ready: first two cycles %b required 10", rdy[1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_neg();
        test_wrap();
        test_not();
        test_random();
        test_back_to_back();
        test_reset_mid_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
